uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 2..4095).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cs  input  1  CPU bus select for this peripheral.
REQ-006 SHALL have port rw  input  1  bus direction, 1 = read, 0 = write.
REQ-007 SHALL have port addr  input  2  register select.
REQ-008 SHALL have port data_in  input  8  CPU write data.
REQ-009 SHALL have port data_out  output  8  registered read data.
REQ-010 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-011 SHALL treat a write as accepted on a clk edge with cs=1, rw=0. Register map: addr 0 = TXDATA (write pushes FIFO), addr 1 = STATUS (read-only), addr 2-3 reserved (writes ignored, reads 0x00).
REQ-012 SHALL return STATUS as bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits 7:4 zero.
REQ-013 SHALL update data_out on the edge that samples cs=1, rw=1, giving read data one cycle later; otherwise data_out holds its value.
REQ-014 SHALL clear overflow on the edge that accepts a STATUS read; if an overflow occurs on that same edge, overflow stays set.
REQ-015 SHALL drop a TXDATA write while count == FIFO_DEPTH and set overflow, even if a pop occurs on the same edge.
REQ-016 SHALL keep FIFO order first-in first-out with wrap-around read/write pointers and a count of 0..FIFO_DEPTH.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte, enter START and drive tx=0 from that edge. A write to an empty FIFO at edge E0 SHALL therefore make tx fall at edge E1.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-time counter that restarts at every state change.
REQ-020 SHALL send DATA bits LSB first using a 3-bit index, then enter PARITY (if enabled) or STOP after bit 7.
REQ-021 SHALL drive tx=1 during STOP for one bit time. On STOP completion: FIFO non-empty -> pop and go directly to START with no idle cycle; otherwise -> IDLE.
REQ-022 SHALL register tx, with no combinational path from any input to tx.
REQ-023 SHALL allow push and pop on the same edge (count unchanged) when 0 < count < FIFO_DEPTH.

Reset
REQ-024 On reset_l=0 the block SHALL immediately set: tx=1, data_out=0x00, FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, bit counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, leave tx high and discard all queued bytes.
REQ-026 After reset_l rises, the first clk edge SHALL behave as a normal operating edge.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the block SHALL add the PARITY state: one bit time carrying even parity (XOR of the 8 data bits), giving an 11-bit frame.
REQ-028 Without UART_TX_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits (10*CLKS_PER_BIT cycles).

Verification
REQ-029 SHALL cover single byte: CLKS_PER_BIT=4, write 0xA5 to addr 0 -> tx low one edge later, then tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; busy=0 afterwards.
REQ-030 SHALL cover back-to-back: write 0x00 then 0xFF -> second start bit directly follows first stop bit, with no extra high cycle.
REQ-031 SHALL cover overflow: with FSM busy and FIFO_DEPTH=8, nine writes -> STATUS reads 0x0D (full, busy, overflow). A second STATUS read shows overflow=0. The ninth byte is never transmitted.
REQ-032 SHALL cover status latency: read addr 1 with FIFO empty and IDLE -> data_out=0x02 exactly one cycle after the read edge.
REQ-033 SHALL cover reset mid-frame: assert reset_l=0 during DATA bit 3 -> tx=1 immediately, STATUS=0x02 after release, queued bytes are not sent.
REQ-034 SHALL cover parity: with UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 11 bit times. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_port.sv
// Bus-attached UART transmitter: FIFO-buffered TXDATA, STATUS register, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = 12;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state;
  logic [BCW-1:0] bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow;

  logic full, empty, busy, wr_req, rd_req, rd_stat, push, pop, ovf_set, bit_done;
  logic [7:0] status;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign wr_req   = cs & ~rw & (addr == 2'd0);
  assign rd_req   = cs & rw;
  assign rd_stat  = rd_req & (addr == 2'd1);
  // A full FIFO drops the write even when the FSM pops on the same edge.
  assign push     = wr_req & ~full;
  assign ovf_set  = wr_req & full;
  assign bit_done = (bit_cnt == BCW'(CLKS_PER_BIT - 1));
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign status   = {4'b0000, overflow, busy, empty, full};

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set wins over the read-clear so an overflow on the read edge is not lost.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)     overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (rd_stat) overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)    data_out <= 8'h00;
    else if (rd_req) data_out <= (addr == 2'd1) ? status : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else bit_cnt <= bit_cnt + BCW'(1);
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shreg;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else bit_cnt <= bit_cnt + BCW'(1);
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end else bit_cnt <= bit_cnt + BCW'(1);
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else state <= IDLE;
          end else bit_cnt <= bit_cnt + BCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_port;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tx;

  int checks = 0;
  int failures = 0;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_l(reset_l), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b0;
    d = data_out;
  endtask

  task automatic capture(input int n, output logic [43:0] obs);
    obs = '0;
    for (int i = 0; i < n; i++) begin
      obs[i] = tx;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [43:0] exp_frame(input logic [7:0] d);
    logic [10:0] b;
    logic [43:0] r;
    b = '0;
    b[0] = 1'b0;
    b[8:1] = d;
`ifdef UART_TX_PARITY_EN
    b[9] = ^d;
    b[10] = 1'b1;
`else
    b[9] = 1'b1;
`endif
    r = '0;
    for (int i = 0; i < FRAME; i++) r[i] = b[i / CPB];
    return r;
  endfunction

  task automatic test_reset;
    tick(2);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    reset_l = 1'b1;
    tick(1);
  endtask

  task automatic test_status_latency;
    logic [7:0] d;
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL stat_before got=%h exp=00", data_out); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL stat_latency got=%h exp=02", d); end
  endtask

  task automatic test_reserved;
    logic [7:0] d;
    bus_write(2'd2, 8'hFF);
    bus_write(2'd3, 8'hEE);
    tick(2);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reserved_tx got=%b exp=1", tx); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reserved_rd got=%h exp=00", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL reserved_stat got=%h exp=02", d); end
  endtask

  task automatic test_single_byte;
    logic [43:0] obs;
    logic [7:0] d;
    bus_write(2'd0, 8'hA5);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL single_pre got=%b exp=1", tx); end
    tick(1);
    capture(FRAME, obs);
    checks++;
    if (obs !== exp_frame(8'hA5))
      begin failures++; $display("FAIL single_frame got=%h exp=%h", obs, exp_frame(8'hA5)); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL single_idle got=%h exp=02", d); end
  endtask

  task automatic test_back_to_back;
    logic [43:0] o1, o2;
    bus_write(2'd0, 8'h00);
    bus_write(2'd0, 8'hFF);
    capture(FRAME, o1);
    capture(FRAME, o2);
    checks++;
    if (o1 !== exp_frame(8'h00))
      begin failures++; $display("FAIL b2b_first got=%h exp=%h", o1, exp_frame(8'h00)); end
    checks++;
    if (o2 !== exp_frame(8'hFF))
      begin failures++; $display("FAIL b2b_second got=%h exp=%h", o2, exp_frame(8'hFF)); end
    tick(2);
  endtask

  task automatic test_overflow;
    logic [43:0] obs;
    logic [7:0] d;
    logic high_ok;
    bus_write(2'd0, 8'h11);
    tick(1);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h20 + 8'(i));
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h0D) begin failures++; $display("FAIL ovf_status got=%h exp=0D", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL ovf_cleared got=%h exp=05", d); end
    tick(FRAME - 11);
    for (int i = 0; i < 8; i++) begin
      capture(FRAME, obs);
      checks++;
      if (obs !== exp_frame(8'h20 + 8'(i)))
        begin failures++; $display("FAIL ovf_frame%0d got=%h exp=%h", i, obs, exp_frame(8'h20 + 8'(i))); end
    end
    high_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (tx !== 1'b1) high_ok = 1'b0;
      tick(1);
    end
    checks++;
    if (high_ok !== 1'b1) begin failures++; $display("FAIL ovf_ninth_sent got=0 exp=1 (line idle)"); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL ovf_final got=%h exp=02", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    logic high_ok;
    bus_write(2'd0, 8'h55);
    bus_write(2'd0, 8'h33);
    tick(17);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL mid_bit3 got=%b exp=0", tx); end
    reset_l = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL mid_async_tx got=%b exp=1", tx); end
    tick(2);
    reset_l = 1'b1;
    tick(1);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL mid_status got=%h exp=02", d); end
    high_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (tx !== 1'b1) high_ok = 1'b0;
      tick(1);
    end
    checks++;
    if (high_ok !== 1'b1) begin failures++; $display("FAIL mid_queued_sent got=0 exp=1 (line idle)"); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [43:0] obs;
    bus_write(2'd0, 8'h07);
    tick(1);
    capture(FRAME, obs);
    checks++;
    if (obs !== exp_frame(8'h07) || obs[9*CPB] !== 1'b1)
      begin failures++; $display("FAIL parity_07 got=%h exp=%h", obs, exp_frame(8'h07)); end
    tick(2);
    bus_write(2'd0, 8'h03);
    tick(1);
    capture(FRAME, obs);
    checks++;
    if (obs !== exp_frame(8'h03) || obs[9*CPB] !== 1'b0)
      begin failures++; $display("FAIL parity_03 got=%h exp=%h", obs, exp_frame(8'h03)); end
    tick(2);
  endtask
`endif

  initial begin
    #1;
    test_reset;
    test_status_latency;
    test_reserved;
    test_single_byte;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
